// File: rtl/calc_pkg.sv
// Shared calculator definitions: converter FSM states, display blank code,
// default operand sizes and the BCD digit-slice helper used by the display path.
// No ports; imported with import calc_pkg::*.
package calc_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Digit code the display decoder renders dark.
  localparam logic [3:0] BLANK_DIGIT = 4'hF;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

  // Widest BCD vector the digit-slice helper accepts.
  localparam int MAX_DIGITS = 16;

  // Return digit k (k=0 is ones) of a packed BCD vector.
  function automatic logic [3:0] bcd_digit(input logic [4*MAX_DIGITS-1:0] v, input int k);
    return v[4*k +: 4];
  endfunction

  // 10^n, used for the elaboration-time digit-count check.
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next decimal digit.
// Ports: d = scratch digit in, q = corrected digit out (4-bit, no carry out).
module bcd_digit_adj
  import calc_pkg::*;
(
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Ports: clk, rst (sync, active-high), start/bin in; busy, done pulse, bcd result out.
// Optional macro BIN2BCD_BLANK_EN: leading zero digits above digit 0 become BLANK_DIGIT.
module bin2bcd_serial
  import calc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WIDTH-1:0]    bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] bcd
);

  localparam int CW = $clog2(WIDTH + 1);

  // Refuse to build a converter whose digits cannot hold the largest input.
  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_too_few
    $fatal(1, "bin2bcd_serial: DIGITS too small for WIDTH");
  end
  if (DIGITS > MAX_DIGITS) begin : g_digits_too_many
    $fatal(1, "bin2bcd_serial: DIGITS exceeds MAX_DIGITS");
  end

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    shreg;
  logic [4*DIGITS-1:0] scratch;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] result;
  logic [CW-1:0]       cnt;

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d (scratch[4*k +: 4]),
      .q (adj[4*k +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // cnt==1 here means the decrement on this edge finishes the last shift.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef BIN2BCD_BLANK_EN
  logic [4*MAX_DIGITS-1:0] ext;
  logic                    leading;
`endif

  // Final digits written to bcd; with blanking, zeros are replaced from the
  // top down until the first nonzero digit, and digit 0 is always kept.
  always_comb begin
    result = scratch;
`ifdef BIN2BCD_BLANK_EN
    ext                   = '0;
    ext[4*DIGITS-1:0]     = scratch;
    leading               = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (leading && (bcd_digit(ext, k) == 4'd0)) result[4*k +: 4] = BLANK_DIGIT;
      else                                         leading = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg   <= '0;
      scratch <= '0;
      cnt     <= '0;
      bcd     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
          end
        end
        SHIFT: begin
          // Corrected digits shift left, taking the next binary MSB as their LSB.
          scratch <= {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
          shreg   <= {shreg[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
        end
        DONE: begin
          bcd  <= result;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_bin2bcd_serial.sv
module tb_bin2bcd_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int checks = 0;
  int errors = 0;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  bin2bcd_serial #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division; in the blank build any digit
  // position above the ones whose place value exceeds v is shown dark.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned p;
    r = '0;
    p = 1;
    for (int d = 0; d < 5; d++) begin
      if (BLANK && d > 0 && v < p) r[4*d +: 4] = 4'hF;
      else                         r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Launch one conversion and wait for done (bounded). lat = edges from the
  // accepting edge to done; bcnt = busy-high cycles seen before done.
  task automatic run_conv(input logic [15:0] v, output int lat, output int bcnt, output bit to);
    start = 1'b1;
    bin   = v;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 16'($urandom);
    lat   = 0;
    bcnt  = 0;
    to    = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        to  = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; bin = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bcd !== 20'h0) begin errors++; $display("FAIL reset_bcd: got %h want 00000", bcd); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_value(input logic [15:0] v, input string name);
    int lat, bcnt; bit to;
    run_conv(v, lat, bcnt, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL %s_timeout: no done within 40 cycles", name); end
    checks++; if (bcd !== ref_bcd(v)) begin errors++; $display("FAIL %s_bcd: got %h want %h", name, bcd, ref_bcd(v)); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL %s_latency: got %0d want 17", name, lat); end
    checks++; if (bcnt !== 16) begin errors++; $display("FAIL %s_busy_cycles: got %0d want 16", name, bcnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done: got %b want 0", name, busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: got %b want 0", name, done); end
    checks++; if (bcd !== ref_bcd(v)) begin errors++; $display("FAIL %s_bcd_hold: got %h want %h", name, bcd, ref_bcd(v)); end
  endtask

  task automatic test_ignore_while_busy;
    int lat, extra; bit to;
    start = 1'b1; bin = 16'd1009;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; bin = 16'd42;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 6; to = 1'b1;
    for (int i = 7; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; to = 1'b0; break; end
    end
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL ignore_timeout: no done within 40 cycles"); end
    checks++; if (lat !== 17) begin errors++; $display("FAIL ignore_latency: got %0d want 17", lat); end
    checks++; if (bcd !== ref_bcd(1009)) begin errors++; $display("FAIL ignore_bcd: got %h want %h", bcd, ref_bcd(1009)); end
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_extra_done: got %0d want 0", extra); end
    checks++; if (bcd !== ref_bcd(1009)) begin errors++; $display("FAIL ignore_bcd_hold: got %h want %h", bcd, ref_bcd(1009)); end
  endtask

  task automatic test_abort;
    int dones;
    start = 1'b1; bin = 16'd12345;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (bcd !== 20'h0) begin errors++; $display("FAIL abort_bcd: got %h want 00000", bcd); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
    dones = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_late_done: got %0d want 0", dones); end
    test_value(16'd7, "after_abort");
  endtask

  task automatic test_back_to_back;
    int last, n, cyc; bit to;
    start = 1'b1; bin = 16'd10;
    n = 0; last = -1; cyc = 0; to = 1'b1;
    for (int i = 1; i <= 120; i++) begin
      @(posedge clk); #1;
      cyc = i;
      if (done) begin
        checks++; if (bcd !== ref_bcd(10)) begin errors++; $display("FAIL hold_bcd: got %h want %h", bcd, ref_bcd(10)); end
        if (last >= 0) begin
          checks++; if (cyc - last !== 18) begin errors++; $display("FAIL hold_interval: got %0d want 18", cyc - last); end
        end
        last = cyc;
        n++;
        if (n == 4) begin to = 1'b0; break; end
      end
    end
    start = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout: got %0d dones want 4", n); end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [15:0] v;
    int lat, bcnt; bit to;
    for (int i = 0; i < 20; i++) begin
      v = 16'($urandom);
      if (i == 0) v = 16'd9;
      if (i == 1) v = 16'd10000;
      run_conv(v, lat, bcnt, to);
      checks++;
      if (to !== 1'b0 || bcd !== ref_bcd(v) || lat !== 17)
        begin errors++; $display("FAIL random_%0d: bin=%0d got bcd=%h lat=%0d want bcd=%h lat=17", i, v, bcd, lat, ref_bcd(v)); end
    end
  endtask

  initial begin
    test_reset();
    test_value(16'd0, "zero");
    test_value(16'd999, "v999");
    test_value(16'd65535, "max");
    test_ignore_while_busy();
    test_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
